// File: rtl/serial_sub_pkg.sv
//------------------------------------------------------------------------------
// Module  : serial_sub_pkg
// Brief   : Shared state encoding and default sizing for serial_subtractor.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_sub_pkg;

  // Operand width used when the instantiating level does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states; encodings are fixed so they read the same in waveforms.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_cell.sv
//------------------------------------------------------------------------------
// Module  : half_subtractor / full_subtractor
// Brief   : 1-bit subtractor cell reused every clock by serial_subtractor.
//           The full subtractor chains two half subtractors; the borrow out
//           is the OR of the two partial borrows.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic w_d1;
  logic w_bo1;
  logic w_bo2;

  // First stage subtracts the operand bits.
  half_subtractor u_hs1 (
    .a  (a),
    .b  (b),
    .d  (w_d1),
    .bo (w_bo1)
  );

  // Second stage subtracts the incoming borrow from the partial difference.
  half_subtractor u_hs2 (
    .a  (w_d1),
    .b  (bin),
    .d  (d),
    .bo (w_bo2)
  );

  assign bo = w_bo1 | w_bo2;

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// Module  : serial_subtractor
// Brief   : Bit-serial a - b controller. One full-subtractor cell processes
//           one bit per clock, LSB first, under a start/done handshake.
//           Optional macro SERIAL_SUB_SIGNED_OVF_EN adds a registered
//           two's-complement overflow flag (ovf).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_t             r_state;
  state_t             w_next;

  // In-flight shadow copies; the visible result registers stay untouched
  // until the final bit has been produced.
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_res;
  logic               r_borrow;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic               w_d;
  logic               w_bo;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_next;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_ovf;
`endif

  full_subtractor u_cell (
    .a   (r_sa[0]),
    .b   (r_sb[0]),
    .bin (r_borrow),
    .d   (w_d),
    .bo  (w_bo)
  );

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // New difference bit enters at the MSB so the result ends up aligned
  // after exactly WIDTH shifts.
  assign w_res_next = (r_res >> 1) | {w_d, {(WIDTH-1){1'b0}}};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: one operation per WIDTH+2 cycles, start only seen in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, bit-serial shift datapath and result commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_sa     <= a;
      r_sb     <= b;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      r_a_msb  <= a[WIDTH-1];
      r_b_msb  <= b[WIDTH-1];
`endif
    end else if (r_state == S_RUN) begin
      r_sa     <= r_sa >> 1;
      r_sb     <= r_sb >> 1;
      r_res    <= w_res_next;
      r_borrow <= w_bo;
      if (w_last) begin
        // Counter parks at zero so it never runs past WIDTH-1.
        r_cnt  <= '0;
        r_diff <= w_res_next;
        r_bout <= w_bo;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        // w_d is the MSB of the final difference.
        r_ovf  <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//------------------------------------------------------------------------------
// Module  : tb_serial_subtractor
// Brief   : Self-checking bench for serial_subtractor (WIDTH=8): directed
//           vector table, back-to-back start stream, async reset abort and
//           random operands against an a-b reference.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (op_a),
    .b     (op_b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation end to end and checks handshake, latency and result.
  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic [W-1:0] ed, input logic eb, input logic eo);
    logic [W-1:0] prev;
    int           lat;
    bit           seen;
    bit           stable;
    @(negedge clk);
    op_a  = ta;
    op_b  = tb;
    start = 1'b1;
    prev  = diff;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    chk({name, " busy"}, 32'(busy), 32'd1);
    lat    = 0;
    seen   = 0;
    stable = 1;
    for (int i = 1; i <= W + 3 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        lat  = i;
      end else if (diff !== prev) begin
        stable = 0;
      end
    end
    chk({name, " latency"}, 32'(lat), 32'(W));
    chk({name, " diff held"}, 32'(stable), 32'd1);
    chk({name, " diff"}, 32'(diff), 32'(ed));
    chk({name, " bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk({name, " ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x ovf for %s", name);
`endif
    @(posedge clk);
    #1;
    chk({name, " done pulse"}, 32'(done), 32'd0);
  endtask

  logic [W-1:0] sa [30];
  logic [W-1:0] sb [30];
  logic [W-1:0] hold_d;
  logic         hold_b;
  logic [W:0]   m;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  bit           stray;

  initial begin
    vecs[0] = '{a: 8'h35, b: 8'h12, d: 8'h23, bo: 1'b0, ov: 1'b0};
    vecs[1] = '{a: 8'h12, b: 8'h35, d: 8'hDD, bo: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    vecs[3] = '{a: 8'hA5, b: 8'hA5, d: 8'h00, bo: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bo: 1'b1, ov: 1'b0};
    vecs[5] = '{a: 8'h80, b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    vecs[6] = '{a: 8'h05, b: 8'h03, d: 8'h02, bo: 1'b0, ov: 1'b0};
    vecs[7] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bo: 1'b0, ov: 1'b0};
    vecs[8] = '{a: 8'h7F, b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset diff", 32'(diff), 32'd0);
    chk("reset bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("reset ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov);
    end

    // start held high with operands changing every cycle: accepts at k=0,10,20.
    for (int k = 0; k < 30; k++) begin
      sa[k] = W'($urandom);
      sb[k] = W'($urandom);
    end
    hold_d = vecs[8].d;
    hold_b = vecs[8].bo;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      op_a  = sa[k];
      op_b  = sb[k];
      start = 1'b1;
      @(posedge clk);
      #1;
      if ((k % 10) == 8) begin
        m      = {1'b0, sa[k-8]} - {1'b0, sb[k-8]};
        hold_d = m[W-1:0];
        hold_b = m[W];
        chk($sformatf("b2b k%0d done", k), 32'(done), 32'd1);
      end else begin
        chk($sformatf("b2b k%0d done", k), 32'(done), 32'd0);
      end
      chk($sformatf("b2b k%0d busy", k), 32'(busy), 32'((k % 10) < 8));
      chk($sformatf("b2b k%0d diff", k), 32'(diff), 32'(hold_d));
      chk($sformatf("b2b k%0d bout", k), 32'(bout), 32'(hold_b));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a run.
    do_op("pre-abort", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    @(negedge clk);
    op_a  = 8'hF0;
    op_b  = 8'h0F;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #4;
    chk("abort pre diff", 32'(diff), 32'h23);
    rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort diff", 32'(diff), 32'd0);
    chk("abort bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    stray = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) stray = 1;
    end
    chk("abort no stray done", 32'(stray), 32'd0);
    do_op("post-abort", 8'h0F, 8'h0F, 8'h00, 1'b0, 1'b0);

    // Random operands against the reference a - b.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      m  = {1'b0, ra} - {1'b0, rb};
      do_op($sformatf("rnd%0d a=%0h b=%0h", n, ra, rb), ra, rb, m[W-1:0], m[W],
            (ra[W-1] ^ rb[W-1]) & (m[W-1] ^ ra[W-1]));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
